key_debounce: RTL and testbench
===============================

# key_debounce

Conditions one raw pushbutton input for the Nios system's PIO key port. It synchronizes the asynchronous pad signal into the `clk` domain and rejects contact bounce with a stable-count filter. It presents a clean, active-high "pressed" level that drives the PIO `in_port` directly. Optional one-cycle press/release strobes serve the rhythm-game timing logic.

## Interface
- `DEBOUNCE_CYCLES`, 1_000_000: consecutive synchronized samples that must disagree with the current level before it flips (20 ms at 50 MHz); legal range ≥ 2.
- `SYNC_STAGES`, 2: flip-flops in the synchronizer chain; legal range ≥ 2.
- `ACTIVE_LOW`, 1: 1 means the pad reads 0 when pressed; 0 means the pad reads 1 when pressed.
- `clk`  input  1: system clock; all state on the rising edge.
- `reset`  input  1: one clock; reset is asynchronous and active-high.
- `key_raw`  input  1: unsynchronized pad signal.
- `key_level`  output  1: debounced state, 1 = pressed; connects to the PIO `in_port`.
- `key_press`  output  1: one-cycle strobe on a debounced 0→1 transition; present only with `KEY_DEBOUNCE_EDGE_EN`.
- `key_release`  output  1: one-cycle strobe on a debounced 1→0 transition; present only with `KEY_DEBOUNCE_EDGE_EN`.

## Operation
- **Synchronizer**
  - Raw input is normalized: `p = key_raw ^ ACTIVE_LOW`, so 1 = pressed.
  - `p` passes through `SYNC_STAGES` flops; `s` is the last stage.
- **FSM states:** `ST_STABLE`, `ST_WAIT`.
- **Counter:** `cnt`, width `$clog2(DEBOUNCE_CYCLES)`.
- **`ST_STABLE`**
  - `s == key_level`: hold; `cnt = 0`.
  - `s != key_level`: go to `ST_WAIT`; `cnt <= 1`.
- **`ST_WAIT`**
  - `s == key_level` (bounce): go to `ST_STABLE`; `cnt <= 0`.
  - `s != key_level` and `cnt < DEBOUNCE_CYCLES-1`: `cnt <= cnt+1`.
  - `s != key_level` and `cnt == DEBOUNCE_CYCLES-1`: `key_level <= ~key_level`; go to `ST_STABLE`; `cnt <= 0`.
- **Transition rule:** the level flips on the `DEBOUNCE_CYCLES`-th consecutive edge at which `s` differs from it.
- **Bounce:** any single agreeing sample restarts the count from zero. There is no partial credit.
- **Counter range:** `cnt` never exceeds `DEBOUNCE_CYCLES-1`; there is no wrap.
- **Strobes** are registered and asserted in the same cycle `key_level` changes. Press and release are mutually exclusive.
- **Reset** (asserted at any time, including mid-`ST_WAIT`):
  - state = `ST_STABLE`, `cnt = 0`, `key_level = 0`;
  - all synchronizer flops = 0 (released);
  - strobes = 0.
- **After reset release:** a key held through reset is reported pressed after the normal filter latency, with a `key_press` strobe.

## Timing
- **Press latency:** `p` changes and is held before rising edge E; `key_level` changes on edge E + `SYNC_STAGES` + `DEBOUNCE_CYCLES` − 1. With defaults: E + 1_000_001.
- **Release latency:** identical to press latency.
- **Strobe width:** exactly one cycle, aligned with the `key_level` change.
- **Glitch rejection:** a glitch on `p` shorter than `DEBOUNCE_CYCLES` clocks never changes `key_level`.
- **Throughput:** no handshake; `key_level` is a continuous level, sampled by the PIO whenever it chooses.
- **Reset:** asynchronous assertion; deassertion is synchronized externally by the system reset controller.

## Configuration
- **Macro:** `KEY_DEBOUNCE_EDGE_EN`.
- **Defined:** the `key_press` and `key_release` ports and their strobe registers exist.
- **Undefined:** both ports and their logic are absent; only `key_level` is produced. FSM and latency are unchanged.

## Structure
- **Package `key_debounce_pkg`:**
  - state typedef `key_db_state_t` {`ST_STABLE`, `ST_WAIT`};
  - constant `KEY_DB_DEFAULT_CYCLES` = 1_000_000;
  - constant `KEY_DB_DEFAULT_SYNC` = 2.
- **Sub-module `key_sync`:** parameterized `SYNC_STAGES` flop chain with asynchronous active-high reset to 0. It is reused for other async inputs, e.g. switches.
- **Top level:** `key_debounce` instantiates `key_sync` and holds the FSM, counter and strobes.

## Test plan
All scenarios use `DEBOUNCE_CYCLES = 4`, `SYNC_STAGES = 2`, `ACTIVE_LOW = 1`.
1. **Clean press:** `key_raw` goes 1→0 before edge 10 and is held → `key_level` 0→1 at edge 15; `key_press` high for exactly edge 15–16; `key_release` stays 0.
2. **Bounce:** `key_raw` 0 for 3 clocks, then 1 for 1 clock, then 0 held from edge 20 → no change before edge 25; `key_level` rises at edge 25.
3. **Short glitch:** a 3-clock low pulse on `key_raw` → `key_level` and both strobes remain 0 throughout.
4. **Clean release:** after a press, `key_raw` returns to 1 before edge 40 → `key_level` 1→0 at edge 45; `key_release` single-cycle pulse; `cnt` observed back at 0.
5. **Reset mid-filter:** `reset` asserted asynchronously with `cnt = 2` in `ST_WAIT` → all outputs 0 immediately. Key held low through reset release at edge 60 → `key_level` rises at edge 65 with a `key_press` strobe.
6. **Macro off:** build without `KEY_DEBOUNCE_EDGE_EN` and rerun scenarios 1–4 → identical `key_level` timing; the strobe ports do not exist.

Source files
------------

// File: rtl/key_debounce_pkg.sv
// rtl/key_debounce_pkg.sv - shared types and defaults for the pushbutton debouncer
package key_debounce_pkg;

   typedef enum logic {
      ST_STABLE = 1'b0,
      ST_WAIT   = 1'b1
   } key_db_state_t;

   localparam int KEY_DB_DEFAULT_CYCLES = 1_000_000;
   localparam int KEY_DB_DEFAULT_SYNC   = 2;

endpackage

// File: rtl/key_sync.sv
// rtl/key_sync.sv - multi-stage synchronizer for one asynchronous input, resets to 0
module key_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic [SYNC_STAGES-1:0] ff;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ff <= '0;
      end else begin
         ff <= {ff[SYNC_STAGES-2:0], d};
      end
   end

   assign q = ff[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// rtl/key_debounce.sv - pushbutton synchronizer plus stable-count debounce filter
// Define KEY_DEBOUNCE_EDGE_EN to add the registered key_press/key_release strobes.
module key_debounce
   import key_debounce_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = KEY_DB_DEFAULT_CYCLES,
   parameter int SYNC_STAGES     = KEY_DB_DEFAULT_SYNC,
   parameter bit ACTIVE_LOW      = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic key_raw,
   output logic key_level
`ifdef KEY_DEBOUNCE_EDGE_EN
   ,
   output logic key_press,
   output logic key_release
`endif
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          p;
   logic          s;
   key_db_state_t state;
   key_db_state_t next_state;
   logic [CW-1:0] cnt;
   logic [CW-1:0] next_cnt;
   logic          flip;

   assign p = key_raw ^ ACTIVE_LOW;

   key_sync #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync (
      .clk  (clk),
      .reset(reset),
      .d    (p),
      .q    (s)
   );

   // Any sample agreeing with the current level throws away the whole count.
   always_comb begin
      next_state = state;
      next_cnt   = '0;
      flip       = 1'b0;
      case (state)
         ST_STABLE: begin
            if (s != key_level) begin
               next_state = ST_WAIT;
               next_cnt   = CW'(1);
            end
         end
         ST_WAIT: begin
            if (s == key_level) begin
               next_state = ST_STABLE;
            end else if (cnt == CNT_LAST) begin
               next_state = ST_STABLE;
               flip       = 1'b1;
            end else begin
               next_cnt = cnt + 1'b1;
            end
         end
         default: begin
            next_state = ST_STABLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= ST_STABLE;
         cnt       <= '0;
         key_level <= 1'b0;
      end else begin
         state     <= next_state;
         cnt       <= next_cnt;
         key_level <= key_level ^ flip;
      end
   end

`ifdef KEY_DEBOUNCE_EDGE_EN
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         key_press   <= 1'b0;
         key_release <= 1'b0;
      end else begin
         key_press   <= flip & ~key_level;
         key_release <= flip & key_level;
      end
   end
`endif

endmodule

// File: tb/tb_key_debounce.sv
// tb/tb_key_debounce.sv - directed bench for key_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
module tb_key_debounce;

   localparam int DC = 4;
   localparam int SS = 2;

   logic clk = 1'b0;
   logic reset;
   logic key_raw;
   logic key_level;
`ifdef KEY_DEBOUNCE_EDGE_EN
   logic key_press;
   logic key_release;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   key_debounce #(
      .DEBOUNCE_CYCLES(DC),
      .SYNC_STAGES    (SS),
      .ACTIVE_LOW     (1'b1)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw),
      .key_level  (key_level)
`ifdef KEY_DEBOUNCE_EDGE_EN
      ,
      .key_press  (key_press),
      .key_release(key_release)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_strobes(input string tag, input logic ep, input logic er);
`ifdef KEY_DEBOUNCE_EDGE_EN
      check({tag, "_press"}, 32'(key_press), 32'(ep));
      check({tag, "_release"}, 32'(key_release), 32'(er));
`endif
   endtask

   // Wait n rising edges, then settle 1 ns so outputs are sampled off the edge.
   task automatic edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      key_raw = 1'b1;
      edges(3);
      check("rst_level", 32'(key_level), 32'd0);
      check("rst_cnt", 32'(dut.cnt), 32'd0);
      check("rst_state", 32'(dut.state), 32'd0);
      check("rst_sync", 32'(dut.u_sync.ff), 32'd0);
      check_strobes("rst", 1'b0, 1'b0);
      reset = 1'b0;
      edges(3);
      check("idle_level", 32'(key_level), 32'd0);

      // clean press: flips on E+5
      key_raw = 1'b0;
      edges(5);
      check("press_pre", 32'(key_level), 32'd0);
      check_strobes("press_pre", 1'b0, 1'b0);
      edges(1);
      check("press_flip", 32'(key_level), 32'd1);
      check_strobes("press_flip", 1'b1, 1'b0);
      edges(1);
      check("press_hold", 32'(key_level), 32'd1);
      check_strobes("press_after", 1'b0, 1'b0);
      check("press_cnt", 32'(dut.cnt), 32'd0);

      // clean release
      key_raw = 1'b1;
      edges(5);
      check("rel_pre", 32'(key_level), 32'd1);
      edges(1);
      check("rel_flip", 32'(key_level), 32'd0);
      check_strobes("rel_flip", 1'b0, 1'b1);
      edges(1);
      check_strobes("rel_after", 1'b0, 1'b0);
      check("rel_cnt", 32'(dut.cnt), 32'd0);
      check("rel_state", 32'(dut.state), 32'd0);

      // bounce: 3 low, 1 high, then low held
      key_raw = 1'b0;
      edges(3);
      key_raw = 1'b1;
      edges(1);
      key_raw = 1'b0;
      edges(1);
      check("bnc_cnt_peak", 32'(dut.cnt), 32'd3);
      edges(1);
      check("bnc_cnt_clr", 32'(dut.cnt), 32'd0);
      check("bnc_state", 32'(dut.state), 32'd0);
      check("bnc_level_a", 32'(key_level), 32'd0);
      edges(3);
      check("bnc_level_b", 32'(key_level), 32'd0);
      edges(1);
      check("bnc_flip", 32'(key_level), 32'd1);
      check_strobes("bnc_flip", 1'b1, 1'b0);

      key_raw = 1'b1;
      edges(6);
      check("bnc_released", 32'(key_level), 32'd0);

      // 3-clock glitch must be rejected
      key_raw = 1'b0;
      edges(3);
      key_raw = 1'b1;
      for (int i = 0; i < 8; i++) begin
         edges(1);
         check("glitch_level", 32'(key_level), 32'd0);
         check_strobes("glitch", 1'b0, 1'b0);
      end

      // reset in the middle of filtering
      key_raw = 1'b0;
      edges(4);
      check("mid_state", 32'(dut.state), 32'd1);
      check("mid_cnt", 32'(dut.cnt), 32'd2);
      #2 reset = 1'b1;
      #1;
      check("arst_cnt", 32'(dut.cnt), 32'd0);
      check("arst_state", 32'(dut.state), 32'd0);
      check("arst_sync", 32'(dut.u_sync.ff), 32'd0);
      check("arst_level", 32'(key_level), 32'd0);
      edges(2);
      reset = 1'b0;
      edges(5);
      check("held_pre", 32'(key_level), 32'd0);
      edges(1);
      check("held_flip", 32'(key_level), 32'd1);
      check_strobes("held_flip", 1'b1, 1'b0);
      edges(1);
      check_strobes("held_after", 1'b0, 1'b0);

      // asynchronous reset while pressed clears the level at once
      #2 reset = 1'b1;
      #1;
      check("arst_pressed", 32'(key_level), 32'd0);
      check_strobes("arst_pressed", 1'b0, 1'b0);
      edges(2);
      reset = 1'b0;
      edges(5);
      check("rehold_pre", 32'(key_level), 32'd0);
      edges(1);
      check("rehold_flip", 32'(key_level), 32'd1);
      check_strobes("rehold_flip", 1'b1, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
